// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: sequential fetch over req/gnt/rvalid memory port, prefetch FIFO, redirect flush.
// Optional macro IFU_MISALIGN_CHECK_EN halts fetch and flags fetch_misalign on a misaligned redirect.
module ifu_prefetch #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h8000_0000),
   parameter int unsigned       PC_STEP    = 4,
   parameter int unsigned       FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              fetch_misalign
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  discard_q, discard_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   entry_t            mem_q [FIFO_DEPTH];

   logic credit_ok_c, halt_c, fire_c, drop_c, push_c, pop_c;
   entry_t head_c;

`ifdef IFU_MISALIGN_CHECK_EN
   logic halted_q, halted_d;

   // Misaligned redirect parks the fetcher until an aligned redirect arrives
   always_comb begin
      halted_d = halted_q;
      if (redirect_valid) halted_d = (redirect_pc[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halted_q <= 1'b0;
      else        halted_q <= halted_d;
   end

   assign halt_c         = halted_q;
   assign fetch_misalign = halted_q;
`else
   assign halt_c         = 1'b0;
   assign fetch_misalign = 1'b0;
`endif

   // Credits cover both buffered entries and in-flight requests, so the FIFO cannot overflow
   assign credit_ok_c = (SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(FIFO_DEPTH);
   assign imem_req    = !redirect_valid && credit_ok_c && !halt_c;
   assign imem_addr   = fetch_pc_q;
   assign fire_c      = imem_req && imem_gnt;
   assign drop_c      = (discard_q != '0);
   assign push_c      = imem_rvalid && !drop_c && !redirect_valid;

   assign head_c      = mem_q[rptr_q];
   assign inst_valid  = (count_q != '0) && !redirect_valid;
   assign inst_o      = (count_q != '0) ? head_c.inst : '0;
   assign inst_pc     = (count_q != '0) ? head_c.pc : '0;
   assign pop_c       = inst_valid && inst_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;

      if (fire_c) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);

      case ({fire_c, imem_rvalid})
         2'b10:   outst_d = outst_q + CNT_W'(1);
         2'b01:   outst_d = outst_q - CNT_W'(1);
         default: outst_d = outst_q;
      endcase

      if (imem_rvalid && drop_c) discard_d = discard_q - CNT_W'(1);

      if (push_c) begin
         resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
         wptr_d    = wptr_q + PTR_W'(1);
      end
      if (pop_c) rptr_d = rptr_q + PTR_W'(1);

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Redirect: every request still in flight becomes stale, including one answered this cycle
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         discard_d  = outst_q - CNT_W'(imem_rvalid);
         count_d    = '0;
         wptr_d     = '0;
         rptr_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   // FIFO storage, written on accepted responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else if (push_c) begin
         mem_q[wptr_q] <= '{pc: resp_pc_q, inst: imem_rdata};
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: per-cycle vector table plus hand-written redirect/misalign sequences.
module tb_ifu_prefetch;

   localparam logic [31:0] B = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_o;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misalign;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int lat    = 1;
   logic [31:0] q_addr[$];
   int          q_due[$];

   ifu_prefetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_misalign(fetch_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          gnt;
      bit          rdy;
      bit          redir;
      logic [31:0] rpc;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vt[$];

   function automatic logic [31:0] inst_of(logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic void add(bit rst, bit gnt, bit rdy, bit redir, logic [31:0] rpc,
                               bit e_req, logic [31:0] e_addr, bit e_valid, logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.gnt = gnt; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      vt.push_back(v);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: record a grant, then present the memory response due in the new cycle
   task automatic step();
      logic        f;
      logic [31:0] a;
      int          d;
      f = imem_req && imem_gnt;
      a = imem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (f) begin
         q_addr.push_back(a);
         q_due.push_back(cyc - 1 + lat);
      end
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = inst_of(q_addr[0]);
         a = q_addr.pop_front();
         d = q_due.pop_front();
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      imem_gnt = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      q_addr.delete();
      q_due.delete();
      #1;
      chk("rst.inst_valid", 32'(inst_valid), 0);
      chk("rst.inst_o", inst_o, 0);
      chk("rst.inst_pc", inst_pc, 0);
      chk("rst.fetch_misalign", 32'(fetch_misalign), 0);
      chk("rst.imem_addr", imem_addr, B);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      bit          found;
      bit          stale;
      int          k;
      rst_n = 1'b0;
      imem_gnt = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;

      // Streaming at 1-cycle latency, then a redirect while the FIFO holds data
      add(1,1,1,0,0,          1,B+32'h00,0,0);
      add(0,1,1,0,0,          1,B+32'h04,0,0);
      add(0,1,1,0,0,          1,B+32'h08,1,B+32'h00);
      add(0,1,1,0,0,          1,B+32'h0C,1,B+32'h04);
      add(0,1,1,0,0,          1,B+32'h10,1,B+32'h08);
      add(0,1,1,0,0,          1,B+32'h14,1,B+32'h0C);
      add(0,1,1,1,B+32'h300,  0,B+32'h18,0,0);
      add(0,1,1,0,0,          1,B+32'h300,0,0);
      add(0,1,1,0,0,          1,B+32'h304,0,0);
      add(0,1,1,0,0,          1,B+32'h308,1,B+32'h300);
      // Decode stalled for 10 cycles: only FIFO_DEPTH grants, then in-order drain
      add(1,1,0,0,0,          1,B+32'h00,0,0);
      add(0,1,0,0,0,          1,B+32'h04,0,0);
      add(0,1,0,0,0,          1,B+32'h08,1,B+32'h00);
      add(0,1,0,0,0,          1,B+32'h0C,1,B+32'h00);
      for (int i = 0; i < 6; i++) add(0,1,0,0,0, 0,B+32'h10,1,B+32'h00);
      add(0,1,1,0,0,          0,B+32'h10,1,B+32'h00);
      add(0,1,1,0,0,          1,B+32'h10,1,B+32'h04);
      add(0,1,1,0,0,          1,B+32'h14,1,B+32'h08);
      add(0,1,1,0,0,          1,B+32'h18,1,B+32'h0C);
      add(0,1,1,0,0,          1,B+32'h1C,1,B+32'h10);
      add(0,1,1,0,0,          1,B+32'h20,1,B+32'h14);
      // Redirect colliding with a response and a raised grant
      add(1,1,1,0,0,          1,B+32'h00,0,0);
      add(0,1,1,1,B+32'h200,  0,B+32'h04,0,0);
      add(0,1,1,0,0,          1,B+32'h200,0,0);
      add(0,1,1,0,0,          1,B+32'h204,0,0);
      add(0,1,1,0,0,          1,B+32'h208,1,B+32'h200);
      // Address wrap at the top of the space, then grant stalls
      add(1,1,1,1,32'hFFFF_FFFC, 0,B,0,0);
      add(0,1,1,0,0,          1,32'hFFFF_FFFC,0,0);
      add(0,1,1,0,0,          1,32'h0000_0000,0,0);
      add(0,1,1,0,0,          1,32'h0000_0004,1,32'hFFFF_FFFC);
      add(0,1,1,0,0,          1,32'h0000_0008,1,32'h0000_0000);
      add(0,0,1,0,0,          1,32'h0000_000C,1,32'h0000_0004);
      add(0,0,1,0,0,          1,32'h0000_000C,1,32'h0000_0008);
      add(0,1,1,0,0,          1,32'h0000_000C,0,0);
      add(0,1,1,0,0,          1,32'h0000_0010,0,0);
      add(0,1,1,0,0,          1,32'h0000_0014,1,32'h0000_000C);

      lat = 1;
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].rst) do_reset();
         imem_gnt       = vt[i].gnt;
         inst_ready     = vt[i].rdy;
         redirect_valid = vt[i].redir;
         redirect_pc    = vt[i].rpc;
         #1;
         chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(vt[i].e_req));
         chk($sformatf("v%0d.addr", i), imem_addr, vt[i].e_addr);
         chk($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(vt[i].e_valid));
         if (vt[i].e_valid) begin
            chk($sformatf("v%0d.pc", i), inst_pc, vt[i].e_pc);
            chk($sformatf("v%0d.inst", i), inst_o, inst_of(vt[i].e_pc));
         end else if (!vt[i].redir) begin
            chk($sformatf("v%0d.pc_empty", i), inst_pc, 0);
            chk($sformatf("v%0d.inst_empty", i), inst_o, 0);
         end
         step();
      end

      // 3-cycle latency, 3 requests in flight, back-to-back redirects (last one wins)
      do_reset();
      lat = 3;
      imem_gnt = 1'b1; inst_ready = 1'b1;
      repeat (3) begin #1; step(); end
      redirect_valid = 1'b1; redirect_pc = B + 32'h500;
      #1;
      chk("t3.req_redir1", 32'(imem_req), 0);
      step();
      redirect_valid = 1'b1; redirect_pc = B + 32'h100;
      #1;
      chk("t3.req_redir2", 32'(imem_req), 0);
      step();
      found = 1'b0; stale = 1'b0; k = 0;
      while (!found && k < 20) begin
         #1;
         if (imem_req && imem_gnt && imem_addr == B + 32'h500) stale = 1'b1;
         if (inst_valid) found = 1'b1;
         else begin step(); k++; end
      end
      chk("t3.valid_seen", 32'(found), 1);
      chk("t3.latency", k, 4);
      chk("t3.no_stale_addr", 32'(stale), 0);
      chk("t3.first_pc", inst_pc, B + 32'h100);
      chk("t3.first_inst", inst_o, inst_of(B + 32'h100));
      step(); #1;
      chk("t3.second_pc", inst_pc, B + 32'h104);
      step(); #1;
      chk("t3.third_pc", inst_pc, B + 32'h108);
      step();

      // Misaligned redirect handling
      do_reset();
      lat = 1;
      imem_gnt = 1'b1; inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = B + 32'h2;
      #1;
      chk("t6.req_redir", 32'(imem_req), 0);
      step(); #1;
`ifdef IFU_MISALIGN_CHECK_EN
      chk("t6.misalign_set", 32'(fetch_misalign), 1);
      chk("t6.req_halted", 32'(imem_req), 0);
      step(); #1;
      chk("t6.misalign_hold", 32'(fetch_misalign), 1);
      chk("t6.req_halted2", 32'(imem_req), 0);
      step();
      redirect_valid = 1'b1; redirect_pc = B + 32'h10;
      #1;
      chk("t6.req_redir_al", 32'(imem_req), 0);
      step(); #1;
      chk("t6.misalign_clr", 32'(fetch_misalign), 0);
      chk("t6.req_resume", 32'(imem_req), 1);
      chk("t6.addr_resume", imem_addr, B + 32'h10);
      step(); #1;
      chk("t6.addr_next", imem_addr, B + 32'h14);
      step(); #1;
      chk("t6.pc_resume", inst_pc, B + 32'h10);
      chk("t6.valid_resume", 32'(inst_valid), 1);
`else
      chk("t6.misalign_tied", 32'(fetch_misalign), 0);
      chk("t6.req_misal", 32'(imem_req), 1);
      chk("t6.addr_misal", imem_addr, B + 32'h2);
      step(); #1;
      chk("t6.addr_next", imem_addr, B + 32'h6);
      step(); #1;
      chk("t6.pc_misal", inst_pc, B + 32'h2);
      chk("t6.valid_misal", 32'(inst_valid), 1);
`endif
      step();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor of the single-cycle IF stage.
- Generates sequential fetch addresses from a reset PC and issues them to instruction memory over a request/grant/response interface that tolerates variable latency.
- Buffers returned instructions with their PCs in a prefetch FIFO.
- Delivers instructions to decode through a valid/ready handshake, and supports redirects (branch/jump/trap) that flush in-flight fetches.

Parameters:
- ADDR_W, 32, fetch address / PC width
- INST_W, 32, instruction width
- RESET_PC, 32'h8000_0000, PC value loaded at reset
- PC_STEP, 4, increment between sequential fetches
- FIFO_DEPTH, 4, prefetch buffer entries; also the maximum number of in-flight requests (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid; responses return in order, at least 1 cycle after grant
- imem_rdata  in  INST_W  response instruction
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts the head
- inst_o  out  INST_W  head instruction
- inst_pc  out  ADDR_W  PC of the head instruction
- redirect_valid  in  1  single-cycle redirect strobe
- redirect_pc  in  ADDR_W  new fetch PC
- fetch_misalign  out  1  misaligned redirect flag (optional feature only; tied 0 otherwise)

Behaviour:

State registers:
- fetch_pc: next address to request.
- resp_pc: PC of the next expected non-stale response.
- outstanding: in-flight request count, including stale ones; width $clog2(FIFO_DEPTH+1).
- discard_cnt: stale responses still to be dropped.
- FIFO of {pc, inst} with count.

Reset (asynchronous, rst_n=0):
- fetch_pc = resp_pc = RESET_PC.
- FIFO empty; outstanding = discard_cnt = 0.
- inst_valid = 0; inst_o = 0; inst_pc = 0; fetch_misalign = 0.
- Reset asserted mid-operation abandons all in-flight state. Responses arriving after release are not counted and must not occur in a compliant system.

Request side:
- imem_req = !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH) [&& !halted, optional feature only].
- imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += PC_STEP (modulo 2^ADDR_W, wraps silently) and outstanding increments.
- imem_addr is held stable while imem_req is high and imem_gnt is low.

Response side:
- On imem_rvalid: outstanding decrements.
- If discard_cnt > 0: drop the data and decrement discard_cnt.
- Otherwise: push {resp_pc, imem_rdata} and advance resp_pc += PC_STEP.
- The credit rule guarantees the FIFO never overflows.
- A simultaneous grant and rvalid leaves outstanding unchanged.

Output side:
- inst_valid = (fifo_count ≠ 0) && !redirect_valid.
- inst_o and inst_pc show the head entry; both read 0 when the FIFO is empty.
- Pop occurs on inst_valid && inst_ready.
- A push and a pop in the same cycle are both honoured; count is unchanged.
- Latency from grant to inst_valid is the memory latency plus 1 cycle (registered FIFO write).

Redirect (redirect_valid=1):
- The FIFO is flushed; no pop occurs that cycle.
- fetch_pc and resp_pc are set to redirect_pc.
- No request is issued that cycle.
- discard_cnt_next = outstanding − imem_rvalid, so a response arriving in the redirect cycle is dropped.
- Back-to-back redirects: the last one wins; discard accounting stays exact.
- First request to redirect_pc occurs the cycle after the strobe.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- With it defined:
  - Reset and redirect set halted = (redirect_pc[1:0] ≠ 0) (0 at reset).
  - While halted: imem_req is forced 0, and fetch_misalign = 1 (registered, asserted the cycle after the redirect).
  - Stale responses are still discarded.
  - A subsequent aligned redirect clears halted and fetch_misalign.
- Without it:
  - fetch_misalign is tied 0.
  - Misaligned redirect_pc values are fetched as given.

Test Plan:
1. Reset release, memory with 1-cycle latency, gnt=1, ready=1 → imem_addr sequence 8000_0000, 8000_0004, 8000_0008…; inst_pc follows 2 cycles behind, inst_o equals the memory contents.
2. ready=0 for 10 cycles → exactly FIFO_DEPTH(4) grants, then imem_req=0; ready=1 → 4 instructions drained in PC order, none lost or duplicated.
3. 3-cycle memory latency with 3 requests in flight, redirect to 8000_0100 → the 3 old responses are dropped, and the next inst_pc is 8000_0100.
4. Redirect in the same cycle as an rvalid and a pending gnt → that response is dropped, no request is issued, and the next imem_addr is redirect_pc.
5. fetch_pc at FFFF_FFFC → next imem_addr is 0000_0000 and inst_pc wraps identically.
6. (IFU_MISALIGN_CHECK_EN) redirect to 8000_0002 → fetch_misalign=1 and imem_req=0 from the next cycle; redirect to 8000_0010 → flag clears and fetching resumes at 8000_0010.
